// File: rtl/apb_master_bridge.sv
// Single-beat request port to APB master: address decode, SETUP/ACCESS sequencing, completion pulse.
// Optional ACCESS-phase watchdog is enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int unsigned NUM_SLAVES      = 4,
    parameter logic [31:0] BASE_ADDR       = 32'h1000_0000,
    parameter int unsigned SLAVE_SPAN_LOG2 = 12,
    parameter int unsigned TIMEOUT_CYCLES  = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     transfer,
    input  logic [31:0]              addr,
    input  logic                     write,
    input  logic [31:0]              wdata,
    output logic                     busy,
    output logic                     ready,
    output logic [31:0]              rdata,
    output logic                     err,
    output logic [31:0]              PADDR,
    output logic                     PWRITE,
    output logic                     PENABLE,
    output logic [31:0]              PWDATA,
    output logic [NUM_SLAVES-1:0]    PSEL,
    input  logic [32*NUM_SLAVES-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]    PREADY
);

    localparam int unsigned TAG_LSB = SLAVE_SPAN_LOG2 + 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [3:0]              r_idx, w_idx_nxt;
    logic                    r_busy, r_ready, r_err, r_pwrite, r_penable;
    logic [31:0]             r_rdata, r_paddr, r_pwdata;
    logic [NUM_SLAVES-1:0]   r_psel;
    logic                    w_ready_nxt, w_err_nxt, w_pwrite_nxt, w_penable_nxt;
    logic [31:0]             w_rdata_nxt, w_paddr_nxt, w_pwdata_nxt;
    logic [NUM_SLAVES-1:0]   w_psel_nxt, w_psel_dec;
    logic [3:0]              w_idx;
    logic                    w_hit, w_sel_ready;
    logic [31:0]             w_sel_rdata;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCNT_W-1:0] r_tcnt, w_tcnt_nxt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 32'd0);
`endif

    assign w_idx = addr[SLAVE_SPAN_LOG2 +: 4];
    assign w_hit = (addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]) && (32'(w_idx) < NUM_SLAVES);

    // AND-OR muxes keyed on the latched slot, so unselected slaves never leak through
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rdata = 32'h0000_0000;
        w_psel_dec  = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            w_sel_ready   = w_sel_ready | (PREADY[i] & (r_idx == 4'(i)));
            w_sel_rdata   = w_sel_rdata | (PRDATA[32*i +: 32] & {32{r_idx == 4'(i)}});
            w_psel_dec[i] = (w_idx == 4'(i));
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_ready_nxt   = 1'b0;
        w_err_nxt     = 1'b0;
        w_rdata_nxt   = r_rdata;
        w_paddr_nxt   = r_paddr;
        w_pwrite_nxt  = r_pwrite;
        w_pwdata_nxt  = r_pwdata;
        w_penable_nxt = r_penable;
        w_psel_nxt    = r_psel;
`ifdef APB_TIMEOUT_EN
        w_tcnt_nxt    = r_tcnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (transfer && w_hit) begin
                    w_paddr_nxt   = addr;
                    w_pwrite_nxt  = write;
                    w_pwdata_nxt  = wdata;
                    w_idx_nxt     = w_idx;
                    w_psel_nxt    = w_psel_dec;
                    w_penable_nxt = 1'b0;
                    w_state_nxt   = ST_SETUP;
                end else if (transfer) begin
                    w_ready_nxt = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = 32'h0000_0000;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            // PREADY is deliberately not looked at here: it may still be held from the last transfer
            ST_SETUP: begin
                w_penable_nxt = 1'b1;
                w_state_nxt   = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                w_tcnt_nxt    = '0;
`endif
            end
            ST_ACCESS: begin
                if (w_sel_ready) begin
                    w_rdata_nxt   = r_pwrite ? 32'h0000_0000 : w_sel_rdata;
                    w_ready_nxt   = 1'b1;
                    w_psel_nxt    = '0;
                    w_penable_nxt = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end else begin
`ifdef APB_TIMEOUT_EN
                    if (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                        w_rdata_nxt   = 32'h0000_0000;
                        w_ready_nxt   = 1'b1;
                        w_err_nxt     = 1'b1;
                        w_psel_nxt    = '0;
                        w_penable_nxt = 1'b0;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        w_tcnt_nxt = r_tcnt + TCNT_W'(1);
                    end
`else
                    w_state_nxt = ST_ACCESS;
`endif
                end
            end
            default: begin
                w_psel_nxt    = '0;
                w_penable_nxt = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_state   <= ST_IDLE;
            r_idx     <= 4'd0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= 32'h0000_0000;
            r_paddr   <= 32'h0000_0000;
            r_pwrite  <= 1'b0;
            r_pwdata  <= 32'h0000_0000;
            r_penable <= 1'b0;
            r_psel    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_ready   <= w_ready_nxt;
            r_err     <= w_err_nxt;
            r_rdata   <= w_rdata_nxt;
            r_paddr   <= w_paddr_nxt;
            r_pwrite  <= w_pwrite_nxt;
            r_pwdata  <= w_pwdata_nxt;
            r_penable <= w_penable_nxt;
            r_psel    <= w_psel_nxt;
        end
    end

`ifdef APB_TIMEOUT_EN
    // ACCESS-phase watchdog count
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= w_tcnt_nxt;
        end
    end
`endif

    assign busy    = r_busy;
    assign ready   = r_ready;
    assign err     = r_err;
    assign rdata   = r_rdata;
    assign PADDR   = r_paddr;
    assign PWRITE  = r_pwrite;
    assign PWDATA  = r_pwdata;
    assign PENABLE = r_penable;
    assign PSEL    = r_psel;

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream stage of every APB peripheral, including GPIO.
- Takes single-beat read/write requests from the core-side request port and drives the APB SETUP/ACCESS protocol.
- Decodes the address into one PSEL per slave, muxes the selected slave's PRDATA/PREADY, and returns a one-cycle completion pulse with read data and an error flag.

Parameters:
- NUM_SLAVES, 4, number of APB slaves (1..16).
- BASE_ADDR, 32'h1000_0000, base of the peripheral window.
- SLAVE_SPAN_LOG2, 12, log2 of bytes per slave slot (4 KB).
- TIMEOUT_CYCLES, 16, ACCESS-phase cycles before abort. Used only with APB_TIMEOUT_EN.

Ports:
- PCLK  in  1  APB clock.
- PRESET  in  1  reset, asynchronous, active-low.
- transfer  in  1  request strobe. Sampled only in IDLE.
- addr  in  32  request byte address.
- write  in  1  1=write, 0=read.
- wdata  in  32  write data.
- busy  out  1  high whenever state != IDLE.
- ready  out  1  one-cycle completion pulse.
- rdata  out  32  read data. Valid while ready=1.
- err  out  1  error flag. Valid while ready=1.
- PADDR  out  32  APB address (full request address).
- PWRITE  out  1  APB direction.
- PENABLE  out  1  APB enable.
- PWDATA  out  32  APB write data.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PRDATA  in  32*NUM_SLAVES  packed slave read data; slave i at bits [32i+31:32i].
- PREADY  in  NUM_SLAVES  per-slave ready.

Behaviour:
- Reset (PRESET=0, async): state=IDLE. ready, err, busy, PENABLE, PWRITE = 0. PSEL=0. PADDR, PWDATA, rdata = 0.
- All outputs are registered.
- Decode:
  - idx = addr[SLAVE_SPAN_LOG2+3:SLAVE_SPAN_LOG2].
  - hit = (addr[31:SLAVE_SPAN_LOG2+4] == BASE_ADDR[31:SLAVE_SPAN_LOG2+4]) && (idx < NUM_SLAVES).
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Edge with transfer=1 and hit: latch addr/write/wdata into PADDR/PWRITE/PWDATA, PSEL[idx]=1, PENABLE=0, go SETUP.
  - Edge with transfer=1 and !hit: no APB activity, stay IDLE; next cycle ready=1, err=1, rdata=0.
  - transfer=0: hold PADDR/PWRITE/PWDATA at their last values.
- SETUP:
  - Lasts exactly one cycle.
  - Next edge sets PENABLE=1 and goes ACCESS.
  - PREADY is ignored in SETUP; a stale PREADY from the previous transfer must not complete it.
- ACCESS:
  - Each edge samples PREADY[idx].
  - If PREADY[idx]=1: rdata <= PRDATA[idx] for reads, rdata <= 0 for writes; ready=1, err=0; PSEL=0, PENABLE=0; go IDLE.
  - Otherwise stay in ACCESS with PSEL, PENABLE, PADDR, PWRITE, PWDATA held stable.
- Latency with a zero-wait slave: ready is high in the 3rd cycle after the accepting edge. Each wait state adds one cycle.
- ready is high for exactly one cycle. err is meaningful only with ready.
- transfer while busy=1 is ignored and not queued. The requester re-issues after ready.
- Back-to-back: transfer=1 in the cycle ready=1 (state IDLE) is accepted, giving the minimum 3-cycle spacing between ready pulses.
- PSEL is never multi-hot. PREADY/PRDATA of unselected slaves are ignored.
- Reset mid-transfer: PSEL and PENABLE drop immediately (async), no ready is generated, and state returns to IDLE.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without PREADY[idx].
  - When it reaches TIMEOUT_CYCLES: PSEL=0, PENABLE=0, ready=1, err=1, rdata=0, go IDLE.
  - A PREADY arriving in the same cycle the count hits the limit wins, and the transfer completes normally.
- Without the macro: ACCESS waits indefinitely, the counter is not synthesized, and TIMEOUT_CYCLES is unused.

Test Plan:
- Write 0x0000_00FF to 0x1000_0000 (slave 0, zero-wait) -> SETUP: PSEL=4'b0001, PENABLE=0. Next cycle PENABLE=1. ready=1, err=0 in the 3rd cycle after acceptance.
- Read 0x1000_1004 with slave 1 asserting PREADY one cycle late and PRDATA=0x0000_00A5 -> ready in the 4th cycle, rdata=0x0000_00A5, err=0, PSEL=4'b0010 throughout.
- Read 0x2000_0000 and 0x1000_5000 (idx 5 with NUM_SLAVES=4) -> PSEL stays 0, ready=1, err=1, rdata=0 the cycle after acceptance.
- Two writes issued back-to-back, the second with transfer=1 during the first's ready cycle -> both complete. The second's SETUP ignores the stale PREADY=1 held over from the first.
- PRESET low during ACCESS of a wait-stalled read -> PSEL=0, PENABLE=0, busy=0 immediately. No ready pulse. A new request after release completes normally.
- With APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never ready -> after 16 ACCESS cycles: ready=1, err=1, PSEL=0. Without the macro, busy remains 1.
